// File: rtl/mcp_lc_pkg.sv
// mcp_lc_pkg: shared constants for the microinstruction sequencer.
// Optional trap entry is enabled by MCP_LC_IRQ_TRAP_EN.
package mcp_lc_pkg;

  localparam int LC_W = 11;
  localparam int MO_W = 22;

  localparam int CTL_HI = 21;
  localparam int CTL_LO = 18;
  localparam int SEL_HI = 12;
  localparam int SEL_LO = 11;
  localparam int TGT_HI = 10;
  localparam int TGT_LO = 0;

  localparam logic [3:0] CTL_JMP  = 4'h8;
  localparam logic [3:0] CTL_JCC  = 4'h9;
  localparam logic [3:0] CTL_CALL = 4'hA;
  localparam logic [3:0] CTL_RET  = 4'hB;
  localparam logic [3:0] CTL_DISP = 4'hC;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } lc_state_t;

  function automatic logic is_rsvd(input logic [3:0] c);
    return c > CTL_DISP;
  endfunction

endpackage

// File: rtl/mcp_lc_stack.sv
// mcp_lc_stack: synchronous return-address LIFO for mcp_lc_seq.
// dout shows the top entry; callers must not push when full or pop when empty.
module mcp_lc_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 11
) (
  input  logic         pin_clk,
  input  logic         pin_rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = $clog2(DEPTH + 1);

  logic [SW-1:0] sp;
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  assign wr_idx = AW'(sp);
  assign rd_idx = AW'(sp - 1'b1);
  assign full   = (sp == SW'(DEPTH));
  assign empty  = (sp == '0);
  assign dout   = empty ? '0 : mem[rd_idx];

  always_ff @(posedge pin_clk) begin
    if (pin_rst) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + 1'b1;
    end else if (pop && !empty) begin
      sp <= sp - 1'b1;
    end
  end

  always_ff @(posedge pin_clk) begin
    if (push && !full) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/mcp_lc_seq.sv
// mcp_lc_seq: two-phase FETCH/EXEC location-counter sequencer for the MicROM.
// Define MCP_LC_IRQ_TRAP_EN to build the trap-on-NEXT/JMP entry path.
module mcp_lc_seq
  import mcp_lc_pkg::*;
#(
  parameter logic [10:0] RESET_LC    = 11'h000,
  parameter logic [10:0] IRQ_LC      = 11'h7F0,
  parameter int          STACK_DEPTH = 4
) (
  input  logic        pin_clk,
  input  logic        pin_rst,
  input  logic        pin_ena,
  input  logic [21:0] pin_mo,
  input  logic [3:0]  pin_cond,
  input  logic [3:0]  pin_vec,
  input  logic        pin_irq,
  output logic [10:0] pin_lc,
  output logic        pin_mov,
  output logic        pin_err,
  output logic        pin_ill
);

  lc_state_t   state;
  logic [3:0]  ctl;
  logic [10:0] tgt;
  logic [10:0] n;
  logic [10:0] nxt;
  logic [10:0] push_val;
  logic        push_req;
  logic        pop_req;
  logic        fault;
  logic        go;
  logic        stk_full;
  logic        stk_empty;
  logic [10:0] stk_dout;
  logic        unused_ok;

  assign ctl = pin_mo[CTL_HI:CTL_LO];
  assign tgt = pin_mo[TGT_HI:TGT_LO];
  assign n   = pin_lc + 11'd1;
  assign go  = (state == ST_EXEC) && pin_ena && !pin_rst;

  assign unused_ok = &{1'b0, pin_mo[17:13], pin_irq, IRQ_LC};

  always_comb begin
    nxt      = n;
    push_val = n;
    push_req = 1'b0;
    pop_req  = 1'b0;
    unique case (1'b1)
      !ctl[3]: nxt = n;
      ctl == CTL_JMP: nxt = tgt;
      ctl == CTL_JCC:
        nxt = pin_cond[pin_mo[SEL_HI:SEL_LO]] ? tgt : n;
      ctl == CTL_CALL: begin
        push_req = 1'b1;
        nxt      = tgt;
      end
      ctl == CTL_RET: begin
        pop_req = 1'b1;
        nxt     = stk_dout;
      end
      ctl == CTL_DISP: nxt = {tgt[10:4], pin_vec};
      default: nxt = n;
    endcase
`ifdef MCP_LC_IRQ_TRAP_EN
    // trap saves the address the word would have gone to
    if (pin_irq && (!ctl[3] || ctl == CTL_JMP)) begin
      push_req = 1'b1;
      push_val = nxt;
      nxt      = IRQ_LC;
    end
`endif
    fault = (push_req && stk_full) || (pop_req && stk_empty);
  end

  assign pin_mov = go;
  assign pin_ill = go && is_rsvd(ctl);

  mcp_lc_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (LC_W)
  ) u_stack (
    .pin_clk (pin_clk),
    .pin_rst (pin_rst),
    .push    (go && push_req && !fault),
    .pop     (go && pop_req && !fault),
    .din     (push_val),
    .dout    (stk_dout),
    .full    (stk_full),
    .empty   (stk_empty)
  );

  always_ff @(posedge pin_clk) begin
    if (pin_rst) begin
      state   <= ST_FETCH;
      pin_lc  <= RESET_LC;
      pin_err <= 1'b0;
    end else if (pin_ena) begin
      case (state)
        ST_FETCH: state <= ST_EXEC;
        ST_EXEC: begin
          if (fault) begin
            pin_err <= 1'b1;
            state   <= ST_HALT;
          end else begin
            pin_lc <= nxt;
            state  <= ST_FETCH;
          end
        end
        default: state <= state;
      endcase
    end
  end

endmodule
